// File: rtl/operand_seq_pkg.sv
// Shared definitions for the operand sequencer: FSM state encodings and
// the default operand width.
package operand_seq_pkg;

    localparam int unsigned OPERAND_WIDTH_DEF = 16;
    localparam int unsigned STATE_W           = 2;

    // Encodings are visible on the State LEDs, so they are fixed explicitly.
    typedef enum logic [STATE_W-1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        ISSUE  = 2'd2,
        DONE   = 2'd3
    } seq_state_e;

endpackage : operand_seq_pkg

// File: rtl/key_debounce.sv
// Pushbutton conditioning: 2-flop synchroniser, optional stability filter
// and falling-edge (press) detector producing a registered one-cycle strobe.
// Optional filter enabled by defining OPERAND_SEQ_DEBOUNCE_EN.
module key_debounce
`ifdef OPERAND_SEQ_DEBOUNCE_EN
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
)
`endif
(
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press_o
);

    logic sync1_q;
    logic sync2_q;
    logic press_d;
    logic press_q;

    // Two-stage synchroniser; resets to the released (high) level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
        end
    end

`ifdef OPERAND_SEQ_DEBOUNCE_EN

    localparam int unsigned CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned CNT_MAX = DEBOUNCE_CYCLES - 1;

    logic             db_d;
    logic             db_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Accept a new level only after it has disagreed for DEBOUNCE_CYCLES cycles.
    always_comb begin
        db_d    = db_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_W'(CNT_MAX)) begin
                db_d  = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        // Strobe on the cycle the filtered level is committed low.
        press_d = db_q & ~db_d;
    end

    // Filter state; debounced level starts released.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db_q  <= 1'b1;
            cnt_q <= '0;
        end else begin
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

`else

    logic lvl_prev_q;

    // Without the filter the synchronised level is the debounced level.
    always_comb begin
        press_d = lvl_prev_q & ~sync2_q;
    end

    // Previous level for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lvl_prev_q <= 1'b1;
        end else begin
            lvl_prev_q <= sync2_q;
        end
    end

`endif

    // Registered press strobe; cleared by reset so none appears right after it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            press_q <= 1'b0;
        end else begin
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule : key_debounce

// File: rtl/operand_sequencer.sv
// Operand sequencer: loads two operands from switches on successive key
// presses, offers the pair downstream with a Valid/Ready handshake, then
// waits for a press to start over.
// Key debounce filter enabled by defining OPERAND_SEQ_DEBOUNCE_EN.
module operand_sequencer
    import operand_seq_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned WIDTH           = OPERAND_WIDTH_DEF
)
(
    input  logic               Clock,
    input  logic               Resetn,
    input  logic [WIDTH-1:0]   SW,
    input  logic               KEY_n,
    input  logic               Clear,
    input  logic               Ready,
    output logic [WIDTH-1:0]   OpA,
    output logic [WIDTH-1:0]   OpB,
    output logic               Valid,
    output logic [STATE_W-1:0] State
);

    // Reject an illegal filter length at elaboration.
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("operand_sequencer: DEBOUNCE_CYCLES must be >= 1");
    end

    logic press;

    // Key conditioning down to a single press strobe.
`ifdef OPERAND_SEQ_DEBOUNCE_EN
    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .clk    (Clock),
        .rst_n  (Resetn),
        .key_n  (KEY_n),
        .press_o(press)
    );
`else
    key_debounce u_key (
        .clk    (Clock),
        .rst_n  (Resetn),
        .key_n  (KEY_n),
        .press_o(press)
    );
`endif

    seq_state_e       state_d;
    seq_state_e       state_q;
    logic [WIDTH-1:0] opa_d;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_d;
    logic [WIDTH-1:0] opb_q;
    logic             valid_d;
    logic             valid_q;

    // Next-state and operand/Valid update; Clear overrides press and handshake.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        valid_d = valid_q;
        if (Clear) begin
            state_d = LOAD_A;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                LOAD_A: begin
                    if (press) begin
                        opa_d   = SW;
                        state_d = LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (press) begin
                        opb_d   = SW;
                        state_d = ISSUE;
                        valid_d = 1'b1;
                    end
                end
                ISSUE: begin
                    if (valid_q && Ready) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                    end
                end
                DONE: begin
                    if (press) begin
                        state_d = LOAD_A;
                    end
                end
                default: begin
                    state_d = LOAD_A;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // Sequencer state; reset wins over every other event.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q <= LOAD_A;
            opa_q   <= '0;
            opb_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            valid_q <= valid_d;
        end
    end

    assign OpA   = opa_q;
    assign OpB   = opb_q;
    assign Valid = valid_q;
    assign State = STATE_W'(state_q);

endmodule : operand_sequencer

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer: directed key/switch sequences, with expected
// operand pairs queued by the stimulus and checked by an output monitor.
module tb_operand_sequencer;

    localparam int unsigned W = 16;
`ifdef OPERAND_SEQ_DEBOUNCE_EN
    localparam int LAT = 7;   // key fall -> State change, DEBOUNCE_CYCLES=4
`else
    localparam int LAT = 4;   // key fall -> State change, no filter
`endif

    logic         Clock;
    logic         Resetn;
    logic [W-1:0] SW;
    logic         KEY_n;
    logic         Clear;
    logic         Ready;
    logic [W-1:0] OpA;
    logic [W-1:0] OpB;
    logic         Valid;
    logic [1:0]   State;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } pair_t;

    pair_t exp_q[$];
    int    checks   = 0;
    int    errors   = 0;
    int    hs_count = 0;

    operand_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .WIDTH          (W)
    ) dut (
        .Clock (Clock),
        .Resetn(Resetn),
        .SW    (SW),
        .KEY_n (KEY_n),
        .Clear (Clear),
        .Ready (Ready),
        .OpA   (OpA),
        .OpB   (OpB),
        .Valid (Valid),
        .State (State)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic press(input logic [W-1:0] sw);
        SW    = sw;
        KEY_n = 1'b0;
        repeat (12) tick();
        KEY_n = 1'b1;
        repeat (12) tick();
    endtask

    // Monitor: while a pair is offered it must match the queued expectation;
    // a handshake consumes it.
    always @(negedge Clock) begin
        if (Resetn && Valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got Valid=1 OpA=%h OpB=%h expected no pair", OpA, OpB);
            end else begin
                check("opa_offered", 32'(OpA), 32'(exp_q[0].a));
                check("opb_offered", 32'(OpB), 32'(exp_q[0].b));
                if (Ready) begin
                    void'(exp_q.pop_front());
                    hs_count++;
                end
            end
        end
    end

    initial begin
        int n;
        int vcount;
        Resetn = 1'b0;
        SW     = '0;
        KEY_n  = 1'b1;
        Clear  = 1'b0;
        Ready  = 1'b0;
        repeat (3) tick();
        Resetn = 1'b1;
        tick();
        check("reset_state", 32'(State), 32'd0);
        check("reset_opa",   32'(OpA),   32'd0);
        check("reset_opb",   32'(OpB),   32'd0);
        check("reset_valid", 32'(Valid), 32'd0);

        // First operand with measured key-to-capture latency.
        exp_q.push_back('{a: 16'h1234, b: 16'h00FF});
        SW    = 16'h1234;
        KEY_n = 1'b0;
        n     = 0;
        while (State != 2'd1 && n < 20) begin
            tick();
            n++;
        end
        check("press_latency", 32'(n), 32'(LAT));
        check("load_a_opa", 32'(OpA), 32'h1234);
        KEY_n = 1'b1;
        repeat (12) tick();
        press(16'h00FF);
        check("issue_opa",   32'(OpA),   32'h1234);
        check("issue_opb",   32'(OpB),   32'h00FF);
        check("issue_state", 32'(State), 32'd2);
        check("issue_valid", 32'(Valid), 32'd1);

        // Valid holds under back-pressure, then one handshake.
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            if (Valid) vcount++;
            tick();
        end
        check("valid_hold_cycles", 32'(vcount), 32'd10);
        Ready = 1'b1;
        tick();
        Ready = 1'b0;
        check("done_state", 32'(State), 32'd3);
        check("done_valid", 32'(Valid), 32'd0);

        // Ready outside ISSUE is ignored; press in DONE returns to LOAD_A.
        Ready = 1'b1;
        repeat (3) tick();
        Ready = 1'b0;
        check("done_ignores_ready", 32'(State), 32'd3);
        press(16'hDEAD);
        check("done_to_load_a", 32'(State), 32'd0);
        check("done_keeps_opa", 32'(OpA), 32'h1234);
        check("done_keeps_opb", 32'(OpB), 32'h00FF);
        Ready = 1'b1;
        repeat (3) tick();
        Ready = 1'b0;
        check("load_a_ignores_ready", 32'(State), 32'd0);

        // Bounced press yields exactly one capture; release yields none.
        SW = 16'hAAAA;
`ifdef OPERAND_SEQ_DEBOUNCE_EN
        KEY_n = 1'b0; tick(); tick();
        KEY_n = 1'b1; tick();
        KEY_n = 1'b0;
        n = 0;
        while (State != 2'd1 && n < 20) begin
            tick();
            n++;
        end
        check("bounce_latency", 32'(n), 32'(LAT));
        repeat (20) tick();
        check("bounce_single_press", 32'(State), 32'd1);
        KEY_n = 1'b1;
        repeat (20) tick();
        check("release_no_press", 32'(State), 32'd1);
`else
        press(16'hAAAA);
        check("release_no_press", 32'(State), 32'd1);
`endif
        check("load_b_opa", 32'(OpA), 32'hAAAA);

        // Clear coincident with a press strobe in LOAD_B.
        SW    = 16'h5555;
        KEY_n = 1'b0;
        repeat (LAT - 1) tick();
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        check("clear_state", 32'(State), 32'd0);
        check("clear_opb",   32'(OpB),   32'h00FF);
        check("clear_opa",   32'(OpA),   32'hAAAA);
        check("clear_valid", 32'(Valid), 32'd0);
        KEY_n = 1'b1;
        repeat (12) tick();
        check("clear_consumed_press", 32'(State), 32'd0);

        // Press during ISSUE is ignored.
        exp_q.push_back('{a: 16'h0001, b: 16'h0002});
        press(16'h0001);
        press(16'h0002);
        check("issue2_state", 32'(State), 32'd2);
        press(16'hFFFF);
        check("issue_ignores_press", 32'(State), 32'd2);
        check("issue_ignores_press_opa", 32'(OpA), 32'h0001);
        Ready = 1'b1;
        tick();
        Ready = 1'b0;
        check("done2_state", 32'(State), 32'd3);
        press(16'h0000);

        // Clear during ISSUE drops the offer and keeps operands.
        exp_q.push_back('{a: 16'hBEEF, b: 16'hCAFE});
        press(16'hBEEF);
        press(16'hCAFE);
        check("issue3_valid", 32'(Valid), 32'd1);
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        exp_q.delete();
        check("issue_clear_state", 32'(State), 32'd0);
        check("issue_clear_valid", 32'(Valid), 32'd0);
        check("issue_clear_opa",   32'(OpA),   32'hBEEF);
        check("issue_clear_opb",   32'(OpB),   32'hCAFE);

        // Reset in ISSUE with Valid high.
        exp_q.push_back('{a: 16'h1111, b: 16'h2222});
        press(16'h1111);
        press(16'h2222);
        check("issue4_valid", 32'(Valid), 32'd1);
        Resetn = 1'b0;
        tick();
        exp_q.delete();
        check("rst_issue_valid", 32'(Valid), 32'd0);
        check("rst_issue_state", 32'(State), 32'd0);
        check("rst_issue_opa",   32'(OpA),   32'd0);
        check("rst_issue_opb",   32'(OpB),   32'd0);
        Resetn = 1'b1;
        repeat (5) tick();
        check("post_reset_idle", 32'(State), 32'd0);

        check("handshake_count", 32'(hs_count), 32'd2);
        check("queue_drained",   32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_operand_sequencer

// File: doc/operand_sequencer.md
OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, the number of consecutive stable cycles needed to accept a key level change (10 ms at 50 MHz); legal range >= 1.
REQ-002 SHALL have parameter WIDTH, default 16, the operand width in bits.
REQ-003 SHALL have port Clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port Resetn  input  1  synchronous, active-low reset.
REQ-005 SHALL have port SW  input  WIDTH  operand value from the board switches.
REQ-006 SHALL have port KEY_n  input  1  active-low pushbutton, asynchronous to Clock.
REQ-007 SHALL have port Clear  input  1  synchronous abort to LOAD_A, active-high.
REQ-008 SHALL have port Ready  input  1  downstream adder can accept an operand pair.
REQ-009 SHALL have port OpA  output  WIDTH  first operand register.
REQ-010 SHALL have port OpB  output  WIDTH  second operand register.
REQ-011 SHALL have port Valid  output  1  OpA/OpB pair offered downstream.
REQ-012 SHALL have port State  output  2  current FSM state, for LED display.

Function
REQ-013 SHALL pass KEY_n through a 2-flop synchroniser before any other use.
REQ-014 SHALL update the debounced key level only after the synchronised level has differed from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the count at 0.
REQ-015 SHALL generate a one-cycle press strobe when the debounced level goes 1->0; a release SHALL generate no strobe.
REQ-016 SHALL implement FSM states LOAD_A=0, LOAD_B=1, ISSUE=2, DONE=3, with State driven directly from the state register.
REQ-017 In LOAD_A, a press SHALL capture SW into OpA and move to LOAD_B.
REQ-018 In LOAD_B, a press SHALL capture SW into OpB and move to ISSUE.
REQ-019 In ISSUE, Valid SHALL be 1 and SHALL stay high until a cycle with Valid=1 and Ready=1; on that cycle the FSM SHALL move to DONE, with Valid=0 from the next cycle.
REQ-020 OpA and OpB SHALL be held stable while Valid=1.
REQ-021 In DONE, a press SHALL move to LOAD_A; OpA and OpB SHALL keep their values until overwritten.
REQ-022 Presses in ISSUE SHALL be ignored; Ready outside ISSUE SHALL be ignored.
REQ-023 Clear=1 SHALL force LOAD_A on the next edge from any state, drop Valid, and leave OpA/OpB unchanged; Clear SHALL take priority over a simultaneous press or handshake.
REQ-024 Valid SHALL be registered; each handshake SHALL transfer exactly one pair.

Reset
REQ-025 Resetn=0 at a rising edge SHALL set State=LOAD_A, OpA=0, OpB=0, Valid=0, synchroniser flops=1, debounced level=1 (released), and debounce counter=0.
REQ-026 Reset SHALL have priority over Clear, press and handshake, including in mid-handshake; no press strobe SHALL be generated in the first cycle after reset.

Configuration
REQ-027 Macro OPERAND_SEQ_DEBOUNCE_EN defined: the debounce filter of REQ-014 SHALL be present.
REQ-028 Macro undefined: the debounced level SHALL equal the synchronised level, a press SHALL strobe 3 cycles after KEY_n falls, DEBOUNCE_CYCLES SHALL be unused, and no counter SHALL be synthesised.

Structure
REQ-029 Package operand_seq_pkg SHALL hold the state encodings (LOAD_A..DONE) and the default operand width constant 16.
REQ-030 Sub-module key_debounce SHALL contain the synchroniser, the optional filter and the press-edge detector, and SHALL output the one-cycle press strobe.

Verification (DEBOUNCE_CYCLES=4, macro defined unless stated)
REQ-031 Reset, then SW=0x1234 and press, then SW=0x00FF and press -> OpA=0x1234, OpB=0x00FF, State=2, Valid=1.
REQ-032 In ISSUE with Ready=0 for 10 cycles, then Ready=1 for 1 cycle -> Valid held high for 10 cycles, exactly one handshake, State=3 next cycle, Valid=0.
REQ-033 KEY_n bounce (low 2 cycles, high 1, low 3, then low steady) -> exactly one press strobe, at the 4th consecutive cycle in which the synchronised level differs from the debounced level.
REQ-034 In LOAD_B, assert Clear in the same cycle as a press strobe -> State=0, OpB unchanged, Valid=0.
REQ-035 Resetn=0 while in ISSUE with Valid=1 -> next cycle Valid=0, State=0, OpA=0, OpB=0.
REQ-036 Macro undefined: single KEY_n fall -> press strobe exactly 3 cycles later; OpA captures SW.
